// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: age-matrix oldest-ready select with tag-broadcast wakeup,
// feeding a single held output register toward register read.
module issue_scheduler #(
    parameter int ENTRIES   = 8,
    parameter int PREG_W    = 6,
    parameter int NUM_WB    = 4,
    parameter int PAYLOAD_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PREG_W-1:0]          disp_src1,
    input  logic [PREG_W-1:0]          disp_src2,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [PREG_W-1:0]          disp_dst,
    input  logic [PAYLOAD_W-1:0]       disp_payload,
    input  logic [NUM_WB-1:0]          wake_valid,
    input  logic [NUM_WB*PREG_W-1:0]   wake_tag,
    output logic                       sel_valid,
    input  logic                       sel_ready,
    output logic [PREG_W-1:0]          sel_src1,
    output logic [PREG_W-1:0]          sel_src2,
    output logic [PREG_W-1:0]          sel_dst,
    output logic [PAYLOAD_W-1:0]       sel_payload,
    output logic [$clog2(ENTRIES):0]   occupancy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0]   valid_q, s1_rdy_q, s2_rdy_q, eligible, blocked;
    logic [PREG_W-1:0]    src1_q    [ENTRIES];
    logic [PREG_W-1:0]    src2_q    [ENTRIES];
    logic [PREG_W-1:0]    dst_q     [ENTRIES];
    logic [PAYLOAD_W-1:0] payload_q [ENTRIES];
    logic [ENTRIES-1:0]   age_q     [ENTRIES];
    logic [IDX_W-1:0]     alloc_idx, pick_idx;
    logic                 pick_found, alloc, load;

    function automatic logic tag_hit(input logic [PREG_W-1:0] tag,
                                     input logic [NUM_WB-1:0] wv,
                                     input logic [NUM_WB*PREG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            if (wv[k] && (wt[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        return hit;
    endfunction

    assign eligible   = valid_q & s1_rdy_q & s2_rdy_q;
    assign disp_ready = (occupancy < CNT_W'(ENTRIES));
    assign alloc      = disp_valid & disp_ready & ~flush;
    assign load       = pick_found & (~sel_valid | sel_ready) & ~flush;

    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end

    // age_q[j][i] set means j is older than i; an entry is blocked by any older eligible one
    always_comb begin
        blocked = '0;
        for (int i = 0; i < ENTRIES; i++)
            for (int j = 0; j < ENTRIES; j++)
                if (eligible[j] && age_q[j][i]) blocked[i] = 1'b1;
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (eligible[i] && !blocked[i]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
                dst_q[i]     <= '0;
                payload_q[i] <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++)
                if (valid_q[i]) begin
                    if (tag_hit(src1_q[i], wake_valid, wake_tag)) s1_rdy_q[i] <= 1'b1;
                    if (tag_hit(src2_q[i], wake_valid, wake_tag)) s2_rdy_q[i] <= 1'b1;
                end
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (load) valid_q[pick_idx] <= 1'b0;
                if (alloc) begin
                    valid_q[alloc_idx]   <= 1'b1;
                    src1_q[alloc_idx]    <= disp_src1;
                    src2_q[alloc_idx]    <= disp_src2;
                    dst_q[alloc_idx]     <= disp_dst;
                    payload_q[alloc_idx] <= disp_payload;
                    s1_rdy_q[alloc_idx]  <= disp_src1_rdy | tag_hit(disp_src1, wake_valid, wake_tag);
                    s2_rdy_q[alloc_idx]  <= disp_src2_rdy | tag_hit(disp_src2, wake_valid, wake_tag);
                    age_q[alloc_idx]     <= '0;
                    for (int j = 0; j < ENTRIES; j++)
                        age_q[j][alloc_idx] <= valid_q[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_valid   <= 1'b0;
            sel_src1    <= '0;
            sel_src2    <= '0;
            sel_dst     <= '0;
            sel_payload <= '0;
            occupancy   <= '0;
        end else if (flush) begin
            sel_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + CNT_W'(alloc) - CNT_W'(load);
            if (load) begin
                sel_valid   <= 1'b1;
                sel_src1    <= src1_q[pick_idx];
                sel_src2    <= src2_q[pick_idx];
                sel_dst     <= dst_q[pick_idx];
                sel_payload <= payload_q[pick_idx];
            end else if (sel_ready) begin
                sel_valid <= 1'b0;
            end
        end
    end
endmodule
